// File: rtl/spi_rom_responder_if.sv
// SPI pins plus backing-memory read port and status flags of the ROM responder.
// The slave modport is the responder side; the master modport is the initiator/memory side.
interface spi_rom_responder_if #(
    parameter int DATA_W = 32
);
    logic              scl;
    logic              mosi;
    logic              miso;
    logic [23:0]       mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic              busy;
    logic              cmd_err;
    logic              underrun;

    modport slave (
        input  scl, mosi, mem_ack, mem_data,
        output miso, mem_addr, mem_req, busy, cmd_err, underrun
    );

    modport master (
        output scl, mosi, mem_ack, mem_data,
        input  miso, mem_addr, mem_req, busy, cmd_err, underrun
    );
endinterface

// File: rtl/spi_rom_responder.sv
// Flash-style SPI target: oversamples scl/mosi on clk, takes an 8-bit command plus
// 24-bit address MSB first, fetches one word from memory and returns it LSB first.
module spi_rom_responder #(
    parameter logic [7:0] CMD_READ     = 8'h0B,
    parameter int         IDLE_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_rom_responder_if.slave   bus
);
    typedef enum logic [1:0] {ST_CMD, ST_FETCH, ST_DATA, ST_IGNORE} state_t;

    localparam logic [5:0] TMO_LAST = 6'(IDLE_TIMEOUT - 1);

    logic         scl_p0, scl_p1, scl_p2;
    logic         mosi_p0, mosi_p1;
    logic         scl_rise, scl_fall;

    state_t       state, state_nxt;
    logic [4:0]   bit_cnt, bit_cnt_nxt;
    logic [5:0]   tmo_cnt, tmo_cnt_nxt;
    logic [31:0]  rx_reg, rx_reg_nxt;
    logic [31:0]  tx_reg, tx_reg_nxt;
    logic [31:0]  rx_shift;
    logic         miso_r, miso_nxt;
    logic         req_r, req_nxt;
    logic [23:0]  addr_r, addr_nxt;
    logic         cmd_err_r, cmd_err_nxt;
    logic         underrun_r, underrun_nxt;
    logic         idle, timeout;

    // Stage p0/p1: two-flop synchronizer; p2 holds previous synchronized scl for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_p0  <= 1'b0;
            scl_p1  <= 1'b0;
            scl_p2  <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            scl_p0  <= bus.scl;
            scl_p1  <= scl_p0;
            scl_p2  <= scl_p1;
            mosi_p0 <= bus.mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign scl_rise = scl_p1 & ~scl_p2;
    assign scl_fall = ~scl_p1 & scl_p2;
    assign rx_shift = {rx_reg[30:0], mosi_p1};
    assign idle     = (state == ST_CMD) && (bit_cnt == 5'd0);
    assign timeout  = !idle && !scl_rise && !scl_fall && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        rx_reg_nxt   = rx_reg;
        tx_reg_nxt   = tx_reg;
        miso_nxt     = miso_r;
        req_nxt      = req_r;
        addr_nxt     = addr_r;
        cmd_err_nxt  = 1'b0;
        underrun_nxt = 1'b0;
        tmo_cnt_nxt  = (scl_rise || scl_fall || idle) ? 6'd0 : tmo_cnt + 6'd1;

        case (state)
            ST_CMD: begin
                if (scl_rise) begin
                    rx_reg_nxt = rx_shift;
                    if (bit_cnt == 5'd31) begin
                        bit_cnt_nxt = 5'd0;
                        if (rx_shift[31:24] == CMD_READ) begin
                            addr_nxt  = rx_shift[23:0];
                            req_nxt   = 1'b1;
                            state_nxt = ST_FETCH;
                        end else begin
                            cmd_err_nxt = 1'b1;
                            state_nxt   = ST_IGNORE;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end
            end

            ST_FETCH: begin
                // An ack coinciding with the first data rise still delivers the word
                if (bus.mem_ack && req_r) begin
                    tx_reg_nxt = bus.mem_data;
                    miso_nxt   = bus.mem_data[0];
                    req_nxt    = 1'b0;
                    state_nxt  = ST_DATA;
                    if (scl_rise) bit_cnt_nxt = 5'd1;
                end else if (scl_rise) begin
                    underrun_nxt = 1'b1;
                    req_nxt      = 1'b0;
                    tx_reg_nxt   = 32'd0;
                    miso_nxt     = 1'b0;
                    bit_cnt_nxt  = 5'd1;
                    state_nxt    = ST_DATA;
                end
            end

            ST_DATA: begin
                if (scl_rise) begin
                    if (bit_cnt == 5'd31) begin
                        miso_nxt    = 1'b0;
                        bit_cnt_nxt = 5'd0;
                        state_nxt   = ST_CMD;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end else if (scl_fall && bit_cnt != 5'd0) begin
                    tx_reg_nxt = {1'b0, tx_reg[31:1]};
                    miso_nxt   = tx_reg[1];
                end
            end

            ST_IGNORE: begin
                miso_nxt = 1'b0;
                if (scl_rise) begin
                    if (bit_cnt == 5'd31) begin
                        bit_cnt_nxt = 5'd0;
                        state_nxt   = ST_CMD;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end
            end

            default: begin
                state_nxt   = ST_CMD;
                bit_cnt_nxt = 5'd0;
            end
        endcase

        // A stalled initiator abandons the frame and withdraws any pending fetch
        if (timeout) begin
            state_nxt   = ST_CMD;
            bit_cnt_nxt = 5'd0;
            miso_nxt    = 1'b0;
            req_nxt     = 1'b0;
            tmo_cnt_nxt = 6'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_CMD;
            bit_cnt    <= 5'd0;
            tmo_cnt    <= 6'd0;
            rx_reg     <= 32'd0;
            tx_reg     <= 32'd0;
            miso_r     <= 1'b0;
            req_r      <= 1'b0;
            addr_r     <= 24'd0;
            cmd_err_r  <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            rx_reg     <= rx_reg_nxt;
            tx_reg     <= tx_reg_nxt;
            miso_r     <= miso_nxt;
            req_r      <= req_nxt;
            addr_r     <= addr_nxt;
            cmd_err_r  <= cmd_err_nxt;
            underrun_r <= underrun_nxt;
        end
    end

    assign bus.miso     = miso_r;
    assign bus.mem_req  = req_r;
    assign bus.mem_addr = addr_r;
    assign bus.busy     = !idle;
    assign bus.cmd_err  = cmd_err_r;
    assign bus.underrun = underrun_r;
endmodule

// File: tb/tb_spi_rom_responder.sv
// Bench for spi_rom_responder: SPI initiator tasks, a latency-configurable memory model
// and a queue of expected read words compared against the words reassembled from miso.
module tb_spi_rom_responder;
    logic clk;
    logic rst;
    spi_rom_responder_if bus ();

    spi_rom_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [0:255];
    logic [31:0] exp_q [$];

    logic ack_en    = 1'b1;
    int   ack_delay = 2;
    int   wait_cnt  = 0;
    int   ack_cnt   = 0;
    int   req_rises = 0;
    int   cmd_errs  = 0;
    int   underruns = 0;
    logic req_prev  = 1'b0;
    logic [23:0] last_addr = 24'd0;

    // Memory model: acks after ack_delay cycles of mem_req, data valid only with ack
    always @(negedge clk) begin
        bus.mem_ack  = 1'b0;
        bus.mem_data = 32'hDEAD_BEEF;
        if (bus.mem_req && ack_en && !rst) begin
            if (wait_cnt >= ack_delay) begin
                bus.mem_ack  = 1'b1;
                bus.mem_data = rom[bus.mem_addr[7:0]];
                wait_cnt     = 0;
                ack_cnt++;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_req && !req_prev) begin
            req_rises++;
            last_addr = bus.mem_addr;
        end
        req_prev = bus.mem_req;
        if (bus.cmd_err)  cmd_errs++;
        if (bus.underrun) underruns++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (time %0t, limit 500000)", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [23:0] addr, input int half,
                             input int data_bits, output logic [31:0] word);
        logic [31:0] f;
        f    = {cmd, addr};
        word = 32'd0;
        for (int i = 31; i >= 0; i--) begin
            bus.mosi = f[i];
            wait_clk(half);
            bus.scl = 1'b1;
            wait_clk(half);
            bus.scl = 1'b0;
        end
        bus.mosi = 1'b0;
        for (int i = 0; i < data_bits; i++) begin
            wait_clk(half);
            word[i] = bus.miso;
            bus.scl = 1'b1;
            wait_clk(half);
            bus.scl = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.scl = 1'b0;
        bus.mosi = 1'b0;
        wait_clk(3);
        checks++;
        if (bus.miso !== 1'b0 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: miso=%b mem_req=%b busy=%b, required 0 0 0",
                     bus.miso, bus.mem_req, bus.busy);
        end
        checks++;
        if (bus.mem_addr !== 24'd0 || bus.cmd_err !== 1'b0 || bus.underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_misc: mem_addr=%h cmd_err=%b underrun=%b, required 000000 0 0",
                     bus.mem_addr, bus.cmd_err, bus.underrun);
        end
        rst = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_basic_read;
        logic [31:0] word, exp;
        int r0, a0;
        r0 = req_rises;
        a0 = ack_cnt;
        exp_q.push_back(rom[8'h23]);
        spi_frame(8'h0B, 24'h000123, 4, 32, word);
        wait_clk(4);
        exp = exp_q.pop_front();
        checks++;
        if (word !== exp) begin
            errors++;
            $display("FAIL basic_data: got %h, required %h", word, exp);
        end
        checks++;
        if (last_addr !== 24'h000123) begin
            errors++;
            $display("FAIL basic_addr: got %h, required 000123", last_addr);
        end
        checks++;
        if (req_rises - r0 != 1 || ack_cnt - a0 != 1) begin
            errors++;
            $display("FAIL basic_handshake: req=%0d ack=%0d, required 1 1",
                     req_rises - r0, ack_cnt - a0);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_end: got %b, required 0", bus.busy);
        end
    endtask

    task automatic test_bad_cmd;
        logic [31:0] word, exp;
        int r0, e0;
        r0 = req_rises;
        e0 = cmd_errs;
        exp_q.push_back(32'd0);
        spi_frame(8'h03, 24'h000055, 4, 32, word);
        wait_clk(4);
        exp = exp_q.pop_front();
        checks++;
        if (word !== exp) begin
            errors++;
            $display("FAIL badcmd_miso: got %h, required %h", word, exp);
        end
        checks++;
        if (cmd_errs - e0 != 1 || req_rises - r0 != 0) begin
            errors++;
            $display("FAIL badcmd_flags: cmd_err pulses=%0d req=%0d, required 1 0",
                     cmd_errs - e0, req_rises - r0);
        end
        exp_q.push_back(rom[8'h04]);
        spi_frame(8'h0B, 24'h000004, 4, 32, word);
        wait_clk(4);
        exp = exp_q.pop_front();
        checks++;
        if (word !== exp) begin
            errors++;
            $display("FAIL badcmd_next: got %h, required %h", word, exp);
        end
    endtask

    task automatic test_underrun;
        logic [31:0] word, exp;
        int u0, a0;
        u0 = underruns;
        a0 = ack_cnt;
        ack_en = 1'b0;
        exp_q.push_back(32'd0);
        spi_frame(8'h0B, 24'h000030, 4, 32, word);
        wait_clk(4);
        exp = exp_q.pop_front();
        checks++;
        if (word !== exp) begin
            errors++;
            $display("FAIL underrun_miso: got %h, required %h", word, exp);
        end
        checks++;
        if (underruns - u0 != 1 || ack_cnt - a0 != 0) begin
            errors++;
            $display("FAIL underrun_pulse: pulses=%0d acks=%0d, required 1 0",
                     underruns - u0, ack_cnt - a0);
        end
        checks++;
        if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL underrun_end: mem_req=%b busy=%b, required 0 0", bus.mem_req, bus.busy);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_timeout;
        logic [31:0] word, exp;
        for (int i = 0; i < 10; i++) begin
            bus.mosi = i[0];
            wait_clk(4);
            bus.scl = 1'b1;
            wait_clk(4);
            bus.scl = 1'b0;
        end
        wait_clk(4);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy_mid: got %b, required 1", bus.busy);
        end
        wait_clk(70);
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abandon: busy=%b mem_req=%b, required 0 0", bus.busy, bus.mem_req);
        end
        exp_q.push_back(rom[8'hFF]);
        spi_frame(8'h0B, 24'hFFFFFF, 4, 32, word);
        wait_clk(4);
        exp = exp_q.pop_front();
        checks++;
        if (word !== exp || last_addr !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL timeout_recover: data=%h addr=%h, required %h FFFFFF", word, last_addr, exp);
        end
    endtask

    task automatic test_reset_mid_data;
        logic [31:0] word, exp;
        spi_frame(8'h0B, 24'h000020, 4, 17, word);
        checks++;
        if (bus.busy !== 1'b1 || bus.miso !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: busy=%b miso=%b, required 1 1", bus.busy, bus.miso);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.miso !== 1'b0 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_abort: miso=%b mem_req=%b busy=%b, required 0 0 0",
                     bus.miso, bus.mem_req, bus.busy);
        end
        wait_clk(2);
        rst = 1'b0;
        wait_clk(2);
        exp_q.push_back(rom[8'h21]);
        spi_frame(8'h0B, 24'h000021, 4, 32, word);
        wait_clk(4);
        exp = exp_q.pop_front();
        checks++;
        if (word !== exp) begin
            errors++;
            $display("FAIL rst_mid_next: got %h, required %h", word, exp);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w0, w1, exp;
        exp_q.push_back(rom[8'h10]);
        exp_q.push_back(rom[8'h11]);
        spi_frame(8'h0B, 24'h000010, 4, 32, w0);
        spi_frame(8'h0B, 24'h000011, 4, 32, w1);
        wait_clk(4);
        exp = exp_q.pop_front();
        checks++;
        if (w0 !== exp) begin
            errors++;
            $display("FAIL b2b_first: got %h, required %h", w0, exp);
        end
        exp = exp_q.pop_front();
        checks++;
        if (w1 !== exp) begin
            errors++;
            $display("FAIL b2b_second: got %h, required %h", w1, exp);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_end: got %b, required 0", bus.busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'(i * 32'h9E37_79B1) ^ 32'h1234_5678;
        rom[8'h23] = 32'h89AB_CDEF;
        rom[8'h10] = 32'h0000_0001;
        rom[8'h11] = 32'h8000_0000;
        rom[8'h20] = 32'hFFFF_FFFF;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 32'hDEAD_BEEF;

        test_reset();
        test_basic_read();
        test_bad_cmd();
        test_underrun();
        test_timeout();
        test_reset_mid_data();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
